// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl: sequencing controller for the keypad entry path.
// Counts captured digits, checks the 4-digit code on ENTER against the stored
// password, drives unlock / err / alarm and clears or gates the digit shift
// register between attempts.
// Build macro PW_CHANGE_EN: when defined, a set_btn press while the door is open
// enters SET, where a new 4-digit password can be stored.
module doorlock_ctrl #(
    parameter logic [15:0] DEFAULT_PW     = 16'h1234,
    parameter int          UNLOCK_CYCLES  = 8,
    parameter int          MAX_FAIL       = 3,
    parameter int          LOCKOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_any,
    input  logic        enter,
    input  logic        clear,
    input  logic        set_btn,
    input  logic [15:0] code_in,
    output logic        key_en,
    output logic        sr_clr,
    output logic [2:0]  digit_cnt,
    output logic        unlock,
    output logic        err,
    output logic        alarm,
    output logic [2:0]  state
);

    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_OPEN    = 3'd2,
        S_FAIL    = 3'd3,
        S_LOCKOUT = 3'd4,
        S_SET     = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      digit_q, digit_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     pw;

    // Button levels are registered once; an event is that registered copy
    // rising relative to its own previous value.  Order is {clear, enter, key}.
    logic [2:0]      btn_cur, btn_prev;
    logic            key_ev, enter_ev, clear_ev;
    logic            match, last_fail;

    // Input capture and one-cycle history for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_cur  <= '0;
            btn_prev <= '0;
        end else begin
            btn_cur  <= {clear, enter, key_any};
            btn_prev <= btn_cur;
        end
    end

    assign key_ev   = btn_cur[0] & ~btn_prev[0];
    assign enter_ev = btn_cur[1] & ~btn_prev[1];
    assign clear_ev = btn_cur[2] & ~btn_prev[2];

`ifdef PW_CHANGE_EN
    logic        set_cur, set_prev, set_ev;
    logic [15:0] pw_q;
    logic        pw_we;

    // Edge detection for the password-change request and the writable password
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_cur  <= 1'b0;
            set_prev <= 1'b0;
            pw_q     <= DEFAULT_PW;
        end else begin
            set_cur  <= set_btn;
            set_prev <= set_cur;
            if (pw_we) begin
                pw_q <= code_in;
            end
        end
    end

    assign set_ev = set_cur & ~set_prev;
    assign pw     = pw_q;
`else
    logic unused_set_btn;

    assign unused_set_btn = set_btn;
    assign pw             = DEFAULT_PW;
`endif

    assign match     = (digit_q == 3'd4) && (code_in == pw);
    assign last_fail = (int'(fail_q) + 1) == MAX_FAIL;

    // FSM, digit counter, failure counter and hold timer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            digit_q <= '0;
            fail_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end

    // Next-state and output decode; clear outranks enter, enter outranks key
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        key_en  = 1'b0;
        sr_clr  = 1'b0;
        unlock  = 1'b0;
        err     = 1'b0;
        alarm   = 1'b0;
`ifdef PW_CHANGE_EN
        pw_we   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                key_en = 1'b1;
                if (clear_ev) begin
                    digit_d = '0;
                    sr_clr  = 1'b1;
                end else if (enter_ev) begin
                    state_d = S_CHECK;
                end else if (key_ev && digit_q != 3'd4) begin
                    digit_d = digit_q + 3'd1;
                end
            end
            S_CHECK: begin
                sr_clr  = 1'b1;
                digit_d = '0;
                if (match) begin
                    state_d = S_OPEN;
                    fail_d  = '0;
                    timer_d = TW'(UNLOCK_CYCLES - 1);
                end else if (last_fail) begin
                    state_d = S_LOCKOUT;
                    fail_d  = '0;
                    timer_d = TW'(LOCKOUT_CYCLES - 1);
                end else begin
                    state_d = S_FAIL;
                    fail_d  = fail_q + FW'(1);
                end
            end
            S_FAIL: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            S_OPEN: begin
                unlock = 1'b1;
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
`ifdef PW_CHANGE_EN
                    if (set_ev) begin
                        state_d = S_SET;
                        sr_clr  = 1'b1;
                        digit_d = '0;
                    end
`endif
                end
            end
            S_LOCKOUT: begin
                alarm = 1'b1;
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
`ifdef PW_CHANGE_EN
            S_SET: begin
                unlock = 1'b1;
                key_en = 1'b1;
                if (clear_ev) begin
                    state_d = S_IDLE;
                    sr_clr  = 1'b1;
                    digit_d = '0;
                end else if (enter_ev) begin
                    state_d = S_IDLE;
                    sr_clr  = 1'b1;
                    digit_d = '0;
                    pw_we   = (digit_q == 3'd4);
                end else if (key_ev && digit_q != 3'd4) begin
                    digit_d = digit_q + 3'd1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign digit_cnt = digit_q;
    assign state     = state_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Testbench for doorlock_ctrl: vector table, directed multi-cycle sequences and
// a randomized phase checked against a behavioural model of the lock.
module tb_doorlock_ctrl;

    localparam logic [15:0] DEFAULT_PW     = 16'h1234;
    localparam int          UNLOCK_CYCLES  = 8;
    localparam int          MAX_FAIL       = 3;
    localparam int          LOCKOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_any = 1'b0, enter = 1'b0, clear = 1'b0, set_btn = 1'b0;
    logic [15:0] code_in = 16'h0000;
    logic        key_en, sr_clr, unlock, err, alarm;
    logic [2:0]  digit_cnt, state;

    int total = 0;
    int bad   = 0;
    bit mchk  = 1'b0;

    doorlock_ctrl #(
        .DEFAULT_PW    (DEFAULT_PW),
        .UNLOCK_CYCLES (UNLOCK_CYCLES),
        .MAX_FAIL      (MAX_FAIL),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_any  (key_any),
        .enter    (enter),
        .clear    (clear),
        .set_btn  (set_btn),
        .code_in  (code_in),
        .key_en   (key_en),
        .sr_clr   (sr_clr),
        .digit_cnt(digit_cnt),
        .unlock   (unlock),
        .err      (err),
        .alarm    (alarm),
        .state    (state)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // mode uses the published state codes; left = remaining high cycles of
    // unlock/alarm including the current one.
    int          m_mode, m_dig, m_fail, m_left;
    logic [15:0] m_pw;
    logic [3:0]  m_cur, m_prev;   // {set, clear, enter, key}

    task automatic model_reset();
        m_mode = 0; m_dig = 0; m_fail = 0; m_left = 0;
        m_pw = DEFAULT_PW; m_cur = '0; m_prev = '0;
    endtask

    task automatic model_step();
        logic [3:0] ev;
        ev = m_cur & ~m_prev;
        case (m_mode)
            0: begin
                if (ev[2]) m_dig = 0;
                else if (ev[1]) m_mode = 1;
                else if (ev[0]) m_dig = (m_dig < 4) ? m_dig + 1 : 4;
            end
            1: begin
                if (m_dig == 4 && code_in == m_pw) begin
                    m_mode = 2; m_left = UNLOCK_CYCLES; m_fail = 0;
                end else if (m_fail + 1 == MAX_FAIL) begin
                    m_mode = 4; m_left = LOCKOUT_CYCLES; m_fail = 0;
                end else begin
                    m_mode = 3; m_fail = m_fail + 1;
                end
                m_dig = 0;
            end
            2, 4: begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = 0;
`ifdef PW_CHANGE_EN
                else if (m_mode == 2 && ev[3]) begin m_mode = 5; m_dig = 0; end
`endif
            end
            3: m_mode = 0;
            5: begin
                if (ev[2]) begin
                    m_mode = 0; m_dig = 0;
                end else if (ev[1]) begin
                    if (m_dig == 4) m_pw = code_in;
                    m_mode = 0; m_dig = 0;
                end else if (ev[0]) begin
                    m_dig = (m_dig < 4) ? m_dig + 1 : 4;
                end
            end
            default: m_mode = 0;
        endcase
        m_prev = m_cur;
        m_cur  = {set_btn, clear, enter, key_any};
    endtask

    function automatic logic [10:0] model_out();
        logic [3:0] ev;
        logic       sr;
        ev = m_cur & ~m_prev;
        sr = (m_mode == 1) || (m_mode == 0 && ev[2]) || (m_mode == 5 && (ev[2] || ev[1]));
`ifdef PW_CHANGE_EN
        sr = sr || (m_mode == 2 && ev[3] && m_left != 1);
`endif
        return {3'(m_mode), 3'(m_dig), (m_mode == 0 || m_mode == 5), sr,
                (m_mode == 2 || m_mode == 5), (m_mode == 3), (m_mode == 4)};
    endfunction

    function automatic logic [10:0] dut_out();
        return {state, digit_cnt, key_en, sr_clr, unlock, err, alarm};
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else model_step();
        #1;
        if (mchk) chk("model", 32'(dut_out()), 32'(model_out()));
    endtask

    task automatic type_digit(input logic [3:0] d);
        code_in = {code_in[11:0], d};
        key_any = 1'b1;
        tick();
        key_any = 1'b0;
        tick();
    endtask

    task automatic type_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) type_digit(c[4*i +: 4]);
    endtask

    int w_unl, w_err, w_al, w_sr, w_chk, w_keal, f_unl, f_err, f_al;

    // Press enter (one cycle) and observe n cycles; optionally hammer keys and
    // enter while the outcome is playing out.
    task automatic run_enter(input int n, input bit poke);
        w_unl = 0; w_err = 0; w_al = 0; w_sr = 0; w_chk = 0; w_keal = 0;
        f_unl = 0; f_err = 0; f_al = 0;
        enter = 1'b1;
        for (int t = 1; t <= n; t++) begin
            tick();
            if (t == 1) enter = 1'b0;
            if (unlock) begin w_unl++; if (f_unl == 0) f_unl = t; end
            if (err)    begin w_err++; if (f_err == 0) f_err = t; end
            if (alarm)  begin w_al++;  if (f_al == 0)  f_al = t;  end
            if (alarm && key_en) w_keal++;
            if (sr_clr) w_sr++;
            if (state == 3'd1) w_chk++;
            if (poke && t >= 4 && t <= 13) begin
                key_any = (t % 2 == 1);
                enter   = (t % 2 == 0);
            end else if (poke && t == 14) begin
                key_any = 1'b0;
                enter   = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        key_any = 0; enter = 0; clear = 0; set_btn = 0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    typedef struct {
        logic        k, e, c;
        logic [15:0] code;
        logic [2:0]  st, dig;
        logic        ke, sc, unl;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic k, input logic e, input logic c, input logic [15:0] code,
                       input logic [2:0] st, input logic [2:0] dig,
                       input logic ke, input logic sc, input logic unl);
        vec_t v;
        v.k = k; v.e = e; v.c = c; v.code = code;
        v.st = st; v.dig = dig; v.ke = ke; v.sc = sc; v.unl = unl;
        tbl.push_back(v);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b0;
        #1 chk("reset_outputs", 32'(dut_out()), 32'(11'b000_000_1_0_0_0_0));
        tick();
        tick();
        rst = 1'b1;

        // Keys 1,2,3,4 then enter: digit counting, CHECK, 8 cycles of unlock.
        add(0,0,0,16'h0000, 0,0,1,0,0);
        add(1,0,0,16'h0001, 0,0,1,0,0);
        add(0,0,0,16'h0001, 0,1,1,0,0);
        add(1,0,0,16'h0012, 0,1,1,0,0);
        add(0,0,0,16'h0012, 0,2,1,0,0);
        add(1,0,0,16'h0123, 0,2,1,0,0);
        add(0,0,0,16'h0123, 0,3,1,0,0);
        add(1,0,0,16'h1234, 0,3,1,0,0);
        add(0,0,0,16'h1234, 0,4,1,0,0);
        add(0,1,0,16'h1234, 0,4,1,0,0);
        add(0,1,0,16'h1234, 1,4,0,1,0);
        add(0,0,0,16'h1234, 2,0,0,0,1);
        for (int i = 0; i < UNLOCK_CYCLES - 1; i++) add(0,0,0,16'h1234, 2,0,0,0,1);
        add(0,0,0,16'h1234, 0,0,1,0,0);
        add(0,0,1,16'h1234, 0,0,1,1,0);
        add(0,0,0,16'h1234, 0,0,1,0,0);
        for (int i = 0; i < tbl.size(); i++) begin
            key_any = tbl[i].k; enter = tbl[i].e; clear = tbl[i].c; code_in = tbl[i].code;
            tick();
            chk($sformatf("vec%0d", i), 32'(dut_out()),
                32'({tbl[i].st, tbl[i].dig, tbl[i].ke, tbl[i].sc, tbl[i].unl, 1'b0, 1'b0}));
        end

        // Wrong code 1235: one err pulse, no unlock.
        type_code(16'h1235);
        run_enter(6, 1'b0);
        chk("wrong_err_cnt", w_err, 1);
        chk("wrong_err_lat", f_err, 3);
        chk("wrong_unlock", w_unl, 0);
        chk("wrong_sr_clr", w_sr, 1);

        // Correct code: unlock 8 cycles, 3 cycles after enter.
        type_code(16'h1234);
        run_enter(14, 1'b0);
        chk("ok_unlock_cnt", w_unl, UNLOCK_CYCLES);
        chk("ok_unlock_lat", f_unl, 3);
        chk("ok_err", w_err, 0);
        chk("ok_digit_cnt", digit_cnt, 0);

        // Three wrong attempts after a success: err, err, then lockout.
        for (int a = 0; a < 2; a++) begin
            type_code(16'h1111);
            run_enter(6, 1'b0);
            chk($sformatf("pre_lock%0d_err", a), w_err, 1);
            chk($sformatf("pre_lock%0d_alarm", a), w_al, 0);
        end
        type_code(16'h1111);
        run_enter(22, 1'b1);
        chk("lock_alarm_cnt", w_al, LOCKOUT_CYCLES);
        chk("lock_alarm_lat", f_al, 3);
        chk("lock_key_en", w_keal, 0);
        chk("lock_err", w_err, 0);
        chk("lock_ignored", {29'd0, state}, 0);
        chk("lock_digit", digit_cnt, 0);
        type_code(16'h1234);
        run_enter(14, 1'b0);
        chk("after_lock_unlock", w_unl, UNLOCK_CYCLES);

        // Only three keys: digit count 3 and the attempt fails.
        code_in = 16'h0000;
        type_digit(4'h1); type_digit(4'h2); type_digit(4'h3);
        chk("three_keys_cnt", digit_cnt, 3);
        run_enter(6, 1'b0);
        chk("three_keys_err", w_err, 1);
        chk("three_keys_unlock", w_unl, 0);

        // Held key counts once.
        key_any = 1'b1;
        repeat (10) tick();
        key_any = 1'b0;
        tick(); tick();
        chk("held_key", digit_cnt, 1);

        // Clear and enter in the same cycle: clear wins, no CHECK.
        clear = 1'b1; enter = 1'b1;
        tick();
        chk("clr_ent_sr_clr", sr_clr, 1);
        clear = 1'b0; enter = 1'b0;
        w_chk = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (state == 3'd1) w_chk++;
        end
        chk("clr_ent_no_check", w_chk, 0);
        chk("clr_ent_digit", digit_cnt, 0);

        // Reset in idle clears the failure count (two fails pending here).
        type_code(16'h1111);
        run_enter(6, 1'b0);
        chk("pre_rst_err", w_err, 1);
        #3 rst = 1'b0;
        #1 chk("idle_rst_outputs", 32'(dut_out()), 32'(11'b000_000_1_0_0_0_0));
        tick();
        rst = 1'b1;
        for (int a = 0; a < 2; a++) begin
            type_code(16'h2222);
            run_enter(6, 1'b0);
            chk($sformatf("post_rst%0d_err", a), w_err, 1);
            chk($sformatf("post_rst%0d_alarm", a), w_al, 0);
        end

        // Asynchronous reset mid-OPEN drops unlock without a clock edge.
        type_code(16'h1234);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick(); tick(); tick();
        chk("open_before_rst", unlock, 1);
        #3 rst = 1'b0;
        #1 chk("open_async_rst", 32'(dut_out()), 32'(11'b000_000_1_0_0_0_0));
        tick();
        rst = 1'b1;

`ifdef PW_CHANGE_EN
        // Change the password to 9876 while open.
        type_code(16'h1234);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick(); tick();
        set_btn = 1'b1;
        tick();
        set_btn = 1'b0;
        tick();
        chk("set_state", state, 5);
        chk("set_unlock", unlock, 1);
        type_code(16'h9876);
        chk("set_digits", digit_cnt, 4);
        chk("set_hold_unlock", unlock, 1);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        chk("set_exit", state, 0);
        type_code(16'h1234);
        run_enter(6, 1'b0);
        chk("old_pw_err", w_err, 1);
        chk("old_pw_unlock", w_unl, 0);
        type_code(16'h9876);
        run_enter(14, 1'b0);
        chk("new_pw_unlock", w_unl, UNLOCK_CYCLES);
`endif

        // Randomized phase against the model.
        do_reset();
        mchk = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            logic k;
            k = ($urandom_range(3) == 0);
            if (k && !key_any) begin
                if ($urandom_range(5) == 0) code_in = 16'h1234;
                else code_in = {code_in[11:0], 4'($urandom_range(9))};
            end
            key_any = k;
            enter   = ($urandom_range(11) == 0);
            clear   = ($urandom_range(29) == 0);
            set_btn = ($urandom_range(9) == 0);
            tick();
        end
        mchk = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/doorlock_ctrl.md
Name: doorlock_ctrl

Overview:
Sequencing controller for the keypad entry path: the one-hot key encoder feeding the 4-stage 4-bit digit shift register. It counts the keystrokes captured by the shift register and checks the 4-digit code on ENTER against the stored password. It drives the unlock output, a failure pulse, and an alarm lockout after repeated failures, and clears or gates the shift register between attempts. It sits between the keypad datapath and the door actuator/indicator logic.

Parameters:
DEFAULT_PW, 16'h1234, power-on password as four BCD digits, oldest digit in [15:12].
UNLOCK_CYCLES, 8, clock cycles unlock is held high.
MAX_FAIL, 3, consecutive failed attempts that trigger lockout (≥1).
LOCKOUT_CYCLES, 16, clock cycles alarm is held high.

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  asynchronous, active-low reset.
key_any  input  1  level OR of the ten key inputs (same signal as the shift register Ce source).
enter  input  1  ENTER button level.
clear  input  1  CLEAR button level.
set_btn  input  1  password-change request (used only with PW_CHANGE_EN).
code_in  input  16  shift register contents {stage3,stage2,stage1,stage0}; stage0 is the newest digit.
key_en  output  1  shift-register capture enable; integration ANDs it with key_any.
sr_clr  output  1  one-cycle synchronous clear pulse to the shift register.
digit_cnt  output  3  digits captured this attempt, 0..4.
unlock  output  1  door open.
err  output  1  one-cycle pulse on a failed attempt.
alarm  output  1  lockout active.
state  output  3  FSM state encoding, for debug/display.

Behaviour:
- Reset (rst=0, async): state=IDLE, digit_cnt=0, fail_cnt=0, timer=0, password register=DEFAULT_PW, edge-detect registers=0. All outputs 0 except key_en=1.
- Edge detection: key_any, enter, clear and set_btn are each registered once; an event is a rising edge (cur=1 and prev=0). Held levels produce exactly one event.
- Event priority within one cycle: clear > enter > key. A lower-priority event in the same cycle is dropped.
- States: IDLE=0, CHECK=1, OPEN=2, FAIL=3, LOCKOUT=4, SET=5.
- IDLE: key_en=1.
  - Key event: digit_cnt=min(digit_cnt+1,4), saturating at 4; the shift register keeps the last four digits.
  - Clear event: digit_cnt=0, sr_clr pulse.
  - Enter event: go to CHECK.
- CHECK (1 cycle, key_en=0): match = (digit_cnt==4) && (code_in==pw).
  - Match: go to OPEN, fail_cnt=0, timer=UNLOCK_CYCLES-1.
  - No match, fail_cnt+1==MAX_FAIL: go to LOCKOUT, timer=LOCKOUT_CYCLES-1, fail_cnt=0.
  - Otherwise: go to FAIL, fail_cnt+1.
  - Every exit from CHECK: sr_clr pulse, digit_cnt=0.
- FAIL (1 cycle): err=1, then IDLE.
- OPEN: unlock=1, key_en=0. timer decrements each cycle; at timer==0, go to IDLE on the next edge. unlock is high for exactly UNLOCK_CYCLES cycles. Key, enter and clear are ignored.
- LOCKOUT: alarm=1, key_en=0, all buttons ignored. Same timer rule: alarm is high for exactly LOCKOUT_CYCLES cycles, then IDLE.
- Latency: ENTER rising edge at the input produces unlock/err/alarm 3 cycles later (edge register, CHECK, output state).
- Timer width: $clog2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES)+1). fail_cnt width: $clog2(MAX_FAIL+1).
- Reset mid-OPEN or mid-LOCKOUT: outputs drop immediately (async); fail_cnt returns to 0.
- Unused state codes recover to IDLE.

Optional Feature:
PW_CHANGE_EN
- Defined: in OPEN, a set_btn event goes to SET. SET asserts sr_clr and zeroes digit_cnt on entry, holds unlock=1 and key_en=1, and counts keys as in IDLE; the OPEN timer is frozen. Enter with digit_cnt==4 stores code_in into the password register and returns to IDLE. Enter with digit_cnt<4, or a clear event, returns to IDLE without changing the password. Both exits pulse sr_clr.
- Undefined: the password register is constant DEFAULT_PW, SET is unreachable, and set_btn is ignored.

Test Plan:
- Default params. Keys 1,2,3,4 (code_in=16'h1234), enter → unlock=1 for exactly 8 cycles starting 3 cycles after enter; sr_clr pulses once; digit_cnt returns to 0.
- Keys 1,2,3,5 then enter → err pulses 1 cycle; unlock stays 0; fail_cnt=1. Then the correct code → unlock, fail_cnt=0.
- Three consecutive wrong codes → third attempt asserts alarm for 16 cycles with key_en=0; enter/keys during lockout have no effect. Afterwards the correct code unlocks.
- Only 3 keys (code_in=16'h0123) then enter → err, not unlock. key_any held high for 10 cycles → digit_cnt rises by 1 only.
- clear and enter rising in the same cycle → sr_clr pulse, digit_cnt=0, no CHECK. rst=0 asserted mid-OPEN → unlock falls without waiting for clk.
- PW_CHANGE_EN: unlock with 1234, set_btn, keys 9,8,7,6, enter → 1234 now fails (err) and 9876 unlocks.
